// File: rtl/bh1750_lux_conv.sv
// BH1750 raw word to lux (raw / 1.2) using a serial divider and a double-dabble BCD stage.
// Define BH1750_ROUND_EN to round half-up to the nearest lux instead of truncating.
module bh1750_lux_conv (
    input  logic        clk,
    input  logic        rstn,
    input  logic        raw_valid,
    input  logic [15:0] raw_data,
    output logic [15:0] lux_bin,
    output logic [19:0] lux_bcd,
    output logic        done,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, DIV, BCD, DONE} state_t;

    state_t      state;
    logic [4:0]  step;
    logic [18:0] quo;
    logic [2:0]  rem;
    logic [19:0] bcd_sr;
    logic        pend_vld;
    logic [15:0] pend_data;

    logic [3:0]  trial;
    logic [3:0]  diff;
    logic        sub_ok;
    logic [19:0] bcd_adj;

    // raw / 1.2 == (raw * 5) / 6; the optional +3 turns truncation into round-half-up.
    function automatic logic [18:0] calc_num(input logic [15:0] raw);
        logic [18:0] n;
        n = ({3'b000, raw} << 2) + {3'b000, raw};
`ifdef BH1750_ROUND_EN
        n = n + 19'd3;
`endif
        return n;
    endfunction

    function automatic logic [19:0] dabble_adj(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // The dividend shifts out of quo's MSB while quotient bits shift in at the LSB.
    always_comb begin
        trial   = {rem, quo[18]};
        sub_ok  = (trial >= 4'd6);
        diff    = trial - 4'd6;
        bcd_adj = dabble_adj(bcd_sr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            step      <= '0;
            quo       <= '0;
            rem       <= '0;
            bcd_sr    <= '0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            lux_bin   <= '0;
            lux_bcd   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            if (raw_valid && state != IDLE) begin
                pend_data <= raw_data;
                pend_vld  <= 1'b1;
                if (pend_vld)
                    overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (raw_valid || pend_vld) begin
                        quo      <= calc_num(raw_valid ? raw_data : pend_data);
                        rem      <= '0;
                        bcd_sr   <= '0;
                        step     <= '0;
                        pend_vld <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DIV;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                DIV: begin
                    quo <= {quo[17:0], sub_ok};
                    rem <= sub_ok ? diff[2:0] : trial[2:0];
                    if (step == 5'd18) begin
                        step  <= '0;
                        state <= BCD;
                    end else begin
                        step <= step + 5'd1;
                    end
                end
                BCD: begin
                    // Rotating the quotient leaves it intact after 16 steps for lux_bin.
                    bcd_sr     <= {bcd_adj[18:0], quo[15]};
                    quo[15:0]  <= {quo[14:0], quo[15]};
                    if (step == 5'd15) begin
                        step  <= '0;
                        state <= DONE;
                    end else begin
                        step <= step + 5'd1;
                    end
                end
                DONE: begin
                    lux_bin <= quo[15:0];
                    lux_bcd <= bcd_sr;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
